// File: rtl/fp_div.sv
// IEEE-754 style divider: restoring divide at one quotient bit per cycle, then normalize and round to nearest even.
// Latency MANTISSA+5 cycles for normal operands, 1 for specials; the result holds while out_ready is low.
module fp_div #(
  parameter int BIT_SIZE = 32,
  parameter int EXPONENT = 8,
  parameter int MANTISSA = 23
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_SIZE-1:0] a_operand,
  input  logic [BIT_SIZE-1:0] b_operand,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] result,
  output logic                Exception,
  output logic                Overflow,
  output logic                Underflow,
  output logic                DivByZero
);

  localparam int MW = MANTISSA + 1;
  localparam int QW = MANTISSA + 3;
  localparam int RW = MANTISSA + 2;
  localparam int EW = EXPONENT + 2;
  localparam int CW = $clog2(QW);
  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXPONENT - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXPONENT) - 1);
  localparam logic signed [EW-1:0] EZERO = '0;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] NORM   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]             state;
  logic [MW-1:0]          divisor;
  logic [RW-1:0]          rem;
  logic [QW-1:0]          quot;
  logic [CW-1:0]          cnt;
  logic signed [EW-1:0]   exp_q;
  logic                   sign_q;

  logic [EXPONENT-1:0]    ea, eb;
  logic [MANTISSA-1:0]    fa, fb;
  logic                   sign_in, any_exc, a_zero, b_zero;

  assign ea      = a_operand[BIT_SIZE-2 -: EXPONENT];
  assign eb      = b_operand[BIT_SIZE-2 -: EXPONENT];
  assign fa      = a_operand[MANTISSA-1:0];
  assign fb      = b_operand[MANTISSA-1:0];
  assign sign_in = a_operand[BIT_SIZE-1] ^ b_operand[BIT_SIZE-1];
  assign any_exc = (&ea) | (&eb);
  // Denormals have exponent 0 and are treated as zero.
  assign a_zero  = ~|ea;
  assign b_zero  = ~|eb;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  logic [RW:0]   rem_sub;
  logic          ge;
  logic [RW-1:0] rem_kept;

  assign rem_sub  = {1'b0, rem} - {2'b00, divisor};
  assign ge       = ~rem_sub[RW];
  assign rem_kept = ge ? rem_sub[RW-1:0] : rem;

  logic                 norm_shift, guard, sticky, round_up, carry;
  logic [QW-1:0]        norm;
  logic [MW:0]          rounded;
  logic [MANTISSA-1:0]  frac;
  logic signed [EW-1:0] exp_fin;
  logic                 ovf, unf;

  assign norm_shift = ~quot[QW-1];
  assign norm       = norm_shift ? {quot[QW-2:0], 1'b0} : quot;
  assign guard      = norm[1];
  assign sticky     = norm[0] | (|rem);
  assign round_up   = guard & (sticky | norm[2]);
  assign rounded    = {1'b0, norm[QW-1:2]} + {{MW{1'b0}}, round_up};
  assign carry      = rounded[MW];
  assign frac       = carry ? rounded[MW-1:1] : rounded[MW-2:0];
  assign exp_fin    = exp_q - EW'(norm_shift) + EW'(carry);
  assign ovf        = (exp_fin >= EMAX);
  assign unf        = (exp_fin <= EZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      divisor   <= '0;
      rem       <= '0;
      quot      <= '0;
      cnt       <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      result    <= '0;
      Exception <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            Exception <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            DivByZero <= 1'b0;
            sign_q    <= sign_in;
            if (any_exc) begin
              result    <= '0;
              Exception <= 1'b1;
              state     <= DONE;
            end else if (b_zero) begin
              result    <= {sign_in, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
              DivByZero <= 1'b1;
              state     <= DONE;
            end else if (a_zero) begin
              result <= {sign_in, {(BIT_SIZE-1){1'b0}}};
              state  <= DONE;
            end else begin
              divisor <= {1'b1, fb};
              rem     <= {2'b01, fa};
              quot    <= '0;
              cnt     <= CW'(QW - 1);
              exp_q   <= EW'(ea) - EW'(eb) + BIAS;
              state   <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          quot <= {quot[QW-2:0], ge};
          rem  <= {rem_kept[RW-2:0], 1'b0};
          cnt  <= cnt - 1'b1;
          if (cnt == '0) state <= NORM;
        end
        NORM: begin
          if (ovf) begin
            result   <= {sign_q, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
            Overflow <= 1'b1;
          end else if (unf) begin
            result    <= {sign_q, {(BIT_SIZE-1){1'b0}}};
            Underflow <= 1'b1;
          end else begin
            result <= {sign_q, exp_fin[EXPONENT-1:0], frac};
          end
          state <= DONE;
        end
        default: begin
          if (out_ready) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: vector table through a scoreboard, plus backpressure and reset-abort sequences.
module tb_fp_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_operand = '0;
  logic [31:0] b_operand = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        Exception, Overflow, Underflow, DivByZero;

  fp_div #(.BIT_SIZE(32), .EXPONENT(8), .MANTISSA(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_operand(a_operand), .b_operand(b_operand), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .Exception(Exception),
    .Overflow(Overflow), .Underflow(Underflow), .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;   // {Exception, Overflow, Underflow, DivByZero}
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [3:0] flags_now();
    return {Exception, Overflow, Underflow, DivByZero};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Called just after a rising edge; leaves the bench just after the acceptance edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check("in_ready before send", {31'b0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    a_operand = a;
    b_operand = b;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    a_operand = $urandom;
    b_operand = $urandom;
  endtask

  task automatic wait_out(input int start, output int lat);
    lat = start;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) check("out_valid timeout", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic compare_out(input string tag, input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, " result"}, result, e.res);
    check({tag, " flags"}, {28'b0, flags_now()}, {28'b0, e.flags});
    check({tag, " latency"}, lat, e.lat);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    sb.push_back('{res: v.res, flags: v.flags, lat: v.lat});
    send(v.a, v.b);
    wait_out(1, lat);
    compare_out(tag, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int   lat;
    int   stale;
    int   held_bad;
    vec_t v;

    vecs.push_back('{a: 32'h40C00000, b: 32'h40000000, res: 32'h40400000, flags: 4'b0000, lat: 28});
    vecs.push_back('{a: 32'h3F800000, b: 32'h40400000, res: 32'h3EAAAAAB, flags: 4'b0000, lat: 28});
    vecs.push_back('{a: 32'hC0000000, b: 32'h00000000, res: 32'hFF800000, flags: 4'b0001, lat: 1});
    vecs.push_back('{a: 32'h7F800000, b: 32'h3F800000, res: 32'h00000000, flags: 4'b1000, lat: 1});
    vecs.push_back('{a: 32'h7F000000, b: 32'h00800000, res: 32'h7F800000, flags: 4'b0100, lat: 28});
    vecs.push_back('{a: 32'h00800000, b: 32'h7F000000, res: 32'h00000000, flags: 4'b0010, lat: 28});
    vecs.push_back('{a: 32'h3F800000, b: 32'h7FC00000, res: 32'h00000000, flags: 4'b1000, lat: 1});
    vecs.push_back('{a: 32'h00000000, b: 32'h40A00000, res: 32'h00000000, flags: 4'b0000, lat: 1});
    vecs.push_back('{a: 32'h80000000, b: 32'h40A00000, res: 32'h80000000, flags: 4'b0000, lat: 1});
    vecs.push_back('{a: 32'h00400000, b: 32'h3F800000, res: 32'h00000000, flags: 4'b0000, lat: 1});
    vecs.push_back('{a: 32'h3F800000, b: 32'h00400000, res: 32'h7F800000, flags: 4'b0001, lat: 1});
    vecs.push_back('{a: 32'h00000000, b: 32'h00000000, res: 32'h7F800000, flags: 4'b0001, lat: 1});
    vecs.push_back('{a: 32'hC0C00000, b: 32'h40000000, res: 32'hC0400000, flags: 4'b0000, lat: 28});
    vecs.push_back('{a: 32'h41200000, b: 32'h40A00000, res: 32'h40000000, flags: 4'b0000, lat: 28});
    vecs.push_back('{a: 32'h40000000, b: 32'h40400000, res: 32'h3F2AAAAB, flags: 4'b0000, lat: 28});
    vecs.push_back('{a: 32'h3F800000, b: 32'h3F800001, res: 32'h3F7FFFFE, flags: 4'b0000, lat: 28});
    vecs.push_back('{a: 32'h3F800000, b: 32'hBF800000, res: 32'hBF800000, flags: 4'b0000, lat: 28});
    vecs.push_back('{a: 32'h7F000000, b: 32'h3F800000, res: 32'h7F000000, flags: 4'b0000, lat: 28});
    vecs.push_back('{a: 32'h7F000000, b: 32'h3F000000, res: 32'h7F800000, flags: 4'b0100, lat: 28});
    vecs.push_back('{a: 32'h00800000, b: 32'h3F800000, res: 32'h00800000, flags: 4'b0000, lat: 28});
    vecs.push_back('{a: 32'h00800000, b: 32'h3FC00000, res: 32'h00000000, flags: 4'b0010, lat: 28});

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset flags", {28'b0, flags_now()}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready after release", {31'b0, in_ready}, 32'd1);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Backpressure, with stray operands offered while busy
    out_ready = 1'b0;
    sb.push_back('{res: 32'h40400000, flags: 4'b0000, lat: 28});
    send(32'h40C00000, 32'h40000000);
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      a_operand = 32'h3F800000;
      b_operand = 32'h00000000;
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    wait_out(lat, lat);
    compare_out("backpressure", lat);
    held_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (result !== 32'h40400000 || !out_valid || in_ready || flags_now() !== 4'b0000) held_bad++;
    end
    check("held while stalled", held_bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("in_ready after handshake", {31'b0, in_ready}, 32'd1);
    check("out_valid after handshake", {31'b0, out_valid}, 32'd0);

    // Reset pulse in the middle of a divide
    send(32'h40C00000, 32'h40000000);
    repeat (9) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("abort out_valid", {31'b0, out_valid}, 32'd0);
    check("abort result", result, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort in_ready", {31'b0, in_ready}, 32'd1);
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("no stale result", stale, 0);
    v = '{a: 32'h3F800000, b: 32'h40400000, res: 32'h3EAAAAAB, flags: 4'b0000, lat: 28};
    run_vec("after abort", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
